// File: rtl/pipelined_shifter.sv
// Elastic barrel shifter: one register per shift level (2^k), valid/ready
// backpressure, flush, and a tag carried unchanged alongside each operand.
module pipelined_shifter #(
    parameter int WIDTH = 16,
    parameter int TAG_W = 4,
    localparam int LEVELS = $clog2(WIDTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_data,
    input  logic [LEVELS-1:0] in_amt,
    input  logic [1:0]        in_mode,
    input  logic [TAG_W-1:0]  in_tag,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_data,
    output logic [TAG_W-1:0]  out_tag,
    output logic              out_zero
);

    typedef enum logic [1:0] {
        MODE_SLL = 2'b00,
        MODE_SRA = 2'b01,
        MODE_ROR = 2'b10,
        MODE_SRL = 2'b11
    } mode_e;

    logic [LEVELS-1:0] valid_q;
    logic [WIDTH-1:0]  data_q [LEVELS];
    mode_e             mode_q [LEVELS];
    logic [LEVELS-1:0] amt_q  [LEVELS];
    logic [TAG_W-1:0]  tag_q  [LEVELS];

    logic [LEVELS-1:0] src_valid;
    logic [WIDTH-1:0]  src_data [LEVELS];
    mode_e             src_mode [LEVELS];
    logic [LEVELS-1:0] src_amt  [LEVELS];
    logic [TAG_W-1:0]  src_tag  [LEVELS];
    logic [WIDTH-1:0]  nxt_data [LEVELS];
    logic [LEVELS-1:0] load;

    function automatic logic [WIDTH-1:0] shift_level(input logic [WIDTH-1:0] d,
                                                     input mode_e m,
                                                     input int unsigned s);
        logic [WIDTH-1:0] r;
        case (m)
            MODE_SLL: r = d << s;
            MODE_SRL: r = d >> s;
            MODE_SRA: r = $signed(d) >>> s;
            MODE_ROR: r = (d >> s) | (d << (WIDTH - s));
            default:  r = d;
        endcase
        return r;
    endfunction

    always_comb begin : stage_sources
        src_valid[0] = in_valid;
        src_data[0]  = in_data;
        src_mode[0]  = mode_e'(in_mode);
        src_amt[0]   = in_amt;
        src_tag[0]   = in_tag;
        for (int unsigned k = 1; k < LEVELS; k++) begin
            src_valid[k] = valid_q[k-1];
            src_data[k]  = data_q[k-1];
            src_mode[k]  = mode_q[k-1];
            src_amt[k]   = amt_q[k-1];
            src_tag[k]   = tag_q[k-1];
        end
    end

    always_comb begin : level_shift
        for (int unsigned k = 0; k < LEVELS; k++) begin
            nxt_data[k] = src_amt[k][k] ? shift_level(src_data[k], src_mode[k], 32'd1 << k)
                                        : src_data[k];
        end
    end

    // Unrolled form of "load_k = !valid_k || load_{k+1}": a stage may load
    // unless it and every stage after it is full while the output is stalled.
    always_comb begin : advance
        logic full;
        for (int unsigned k = 0; k < LEVELS; k++) begin
            full = 1'b1;
            for (int unsigned j = k; j < LEVELS; j++) begin
                full = full & valid_q[j];
            end
            load[k] = out_ready | ~full;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int unsigned k = 0; k < LEVELS; k++) begin
                data_q[k] <= '0;
                mode_q[k] <= MODE_SLL;
                amt_q[k]  <= '0;
                tag_q[k]  <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < LEVELS; k++) begin
                if (flush) begin
                    valid_q[k] <= 1'b0;
                end else if (load[k]) begin
                    valid_q[k] <= src_valid[k];
                end
                if (load[k]) begin
                    data_q[k] <= nxt_data[k];
                    mode_q[k] <= src_mode[k];
                    amt_q[k]  <= src_amt[k];
                    tag_q[k]  <= src_tag[k];
                end
            end
        end
    end

    assign in_ready  = load[0];
    assign out_valid = valid_q[LEVELS-1];
    assign out_data  = data_q[LEVELS-1];
    assign out_tag   = tag_q[LEVELS-1];
    assign out_zero  = (out_data == '0);

endmodule

// File: tb/tb_pipelined_shifter.sv
// Scoreboard bench for pipelined_shifter: a 16-bit/4-tag instance covering
// modes, streaming, backpressure, flush and reset, plus a 32-bit/1-tag instance.
module tb_pipelined_shifter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        in_valid = 1'b0, in_ready, flush = 1'b0;
    logic [15:0] in_data = '0;
    logic [3:0]  in_amt = '0;
    logic [1:0]  in_mode = '0;
    logic [3:0]  in_tag = '0;
    logic        out_valid, out_ready = 1'b1, out_zero;
    logic [15:0] out_data;
    logic [3:0]  out_tag;

    logic        w_in_valid = 1'b0, w_in_ready, w_flush = 1'b0;
    logic [31:0] w_in_data = '0;
    logic [4:0]  w_in_amt = '0;
    logic [1:0]  w_in_mode = '0;
    logic [0:0]  w_in_tag = '0;
    logic        w_out_valid, w_out_ready = 1'b1, w_out_zero;
    logic [31:0] w_out_data;
    logic [0:0]  w_out_tag;

    pipelined_shifter #(.WIDTH(16), .TAG_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_amt(in_amt), .in_mode(in_mode), .in_tag(in_tag),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_tag(out_tag), .out_zero(out_zero)
    );

    pipelined_shifter #(.WIDTH(32), .TAG_W(1)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(w_in_valid), .in_ready(w_in_ready),
        .in_data(w_in_data), .in_amt(w_in_amt), .in_mode(w_in_mode), .in_tag(w_in_tag),
        .flush(w_flush), .out_valid(w_out_valid), .out_ready(w_out_ready),
        .out_data(w_out_data), .out_tag(w_out_tag), .out_zero(w_out_zero)
    );

    typedef struct {
        logic [31:0] data;
        logic [3:0]  tag;
        int unsigned acc;
        bit          chk_lat;
    } exp_t;

    exp_t q16[$];
    exp_t q32[$];
    exp_t m16, m32;
    int n_checks = 0;
    int n_fail = 0;
    int unsigned cyc = 0;
    bit lat_chk = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] ref16(input logic [15:0] d, input logic [3:0] a,
                                          input logic [1:0] m);
        logic [31:0] dd;
        logic [15:0] r;
        dd = {d, d} >> a;
        case (m)
            2'b00:   r = d << a;
            2'b01:   r = $signed(d) >>> a;
            2'b10:   r = dd[15:0];
            default: r = d >> a;
        endcase
        return r;
    endfunction

    // Monitors: pop one expectation per output handshake.
    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            if (q16.size() == 0) begin
                check("unexpected_out16", 32'(out_valid), 32'd0);
            end else begin
                m16 = q16.pop_front();
                check("data16", 32'(out_data), m16.data);
                check("tag16", 32'(out_tag), 32'(m16.tag));
                check("zero16", 32'(out_zero), 32'(m16.data == 32'd0));
                if (m16.chk_lat) check("latency16", cyc - m16.acc + 1, 32'd4);
            end
        end
    end

    always @(negedge clk) begin
        if (w_out_valid && w_out_ready) begin
            if (q32.size() == 0) begin
                check("unexpected_out32", 32'(w_out_valid), 32'd0);
            end else begin
                m32 = q32.pop_front();
                check("data32", w_out_data, m32.data);
                check("tag32", 32'(w_out_tag), 32'(m32.tag));
                check("zero32", 32'(w_out_zero), 32'(m32.data == 32'd0));
                check("latency32", cyc - m32.acc + 1, 32'd5);
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send16(input logic [15:0] d, input logic [3:0] a, input logic [1:0] m,
                          input logic [3:0] t, input logic [15:0] exp, output int waits);
        exp_t e;
        bit done;
        in_valid = 1'b1; in_data = d; in_amt = a; in_mode = m; in_tag = t;
        waits = 0;
        done = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                e.data = 32'(exp); e.tag = t; e.acc = cyc + 1; e.chk_lat = lat_chk;
                q16.push_back(e);
                done = 1'b1;
            end else begin
                waits++;
                if (waits > 60) begin
                    check("send16_timeout", 32'(in_ready), 32'd1);
                    done = 1'b1;
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic send32(input logic [31:0] d, input logic [4:0] a, input logic [1:0] m,
                          input logic t, input logic [31:0] exp);
        exp_t e;
        w_in_valid = 1'b1; w_in_data = d; w_in_amt = a; w_in_mode = m; w_in_tag = t;
        @(negedge clk);
        check("in_ready32", 32'(w_in_ready), 32'd1);
        if (w_in_ready) begin
            e.data = exp; e.tag = 4'(t); e.acc = cyc + 1; e.chk_lat = 1'b1;
            q32.push_back(e);
        end
        @(posedge clk); #1;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((q16.size() != 0 || q32.size() != 0) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check(name, 32'(q16.size() + q32.size()), 32'd0);
    endtask

    logic [15:0] dir_d [5] = '{16'h0001, 16'h8000, 16'h7FF0, 16'h8000, 16'h1234};
    logic [3:0]  dir_a [5] = '{4'd15, 4'd15, 4'd4, 4'd15, 4'd4};
    logic [1:0]  dir_m [5] = '{2'b00, 2'b01, 2'b01, 2'b11, 2'b10};
    logic [15:0] dir_e [5] = '{16'h8000, 16'hFFFF, 16'h07FF, 16'h0001, 16'h4123};

    logic [15:0] bp_d [6] = '{16'h00F0, 16'hF000, 16'h8001, 16'h000F, 16'hFFFF, 16'hABCD};
    logic [3:0]  bp_a [6] = '{4'd4, 4'd8, 4'd1, 4'd8, 4'd0, 4'd12};
    logic [1:0]  bp_m [6] = '{2'b00, 2'b11, 2'b01, 2'b10, 2'b00, 2'b10};
    logic [15:0] bp_e [6] = '{16'h0F00, 16'h00F0, 16'hC000, 16'h0F00, 16'hFFFF, 16'hBCDA};

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got no end, expected end");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        logic [15:0] d;
        logic [3:0] a;
        logic [1:0] m;

        #12;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_data", 32'(out_data), 32'd0);
        check("reset_out_tag", 32'(out_tag), 32'd0);
        check("reset_out_zero", 32'(out_zero), 32'd1);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed mode vectors, back to back
        for (int i = 0; i < 5; i++) send16(dir_d[i], dir_a[i], dir_m[i], 4'(i + 10), dir_e[i], w);
        in_valid = 1'b0;
        drain("drain_directed");

        // Streaming against the reference model; every fifth op uses amt = 0
        for (int i = 0; i < 20; i++) begin
            d = 16'($urandom);
            a = (i % 5 == 0) ? 4'd0 : 4'($urandom_range(15));
            m = 2'($urandom_range(3));
            send16(d, a, m, 4'(i), ref16(d, a, m), w);
            check("stream_in_ready_waits", 32'(w), 32'd0);
        end
        in_valid = 1'b0;
        drain("drain_stream");

        // Backpressure: consumer stalled for 10 cycles
        lat_chk = 1'b0;
        out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 6; i++) send16(bp_d[i], bp_a[i], bp_m[i], 4'(i + 1), bp_e[i], w);
                in_valid = 1'b0;
            end
            begin
                repeat (6) @(posedge clk);
                #2;
                check("bp_in_ready_full", 32'(in_ready), 32'd0);
                check("bp_hold_data_a", 32'(out_data), 32'h0F00);
                check("bp_hold_tag_a", 32'(out_tag), 32'd1);
                repeat (4) @(posedge clk);
                #2;
                check("bp_in_ready_full_b", 32'(in_ready), 32'd0);
                check("bp_hold_data_b", 32'(out_data), 32'h0F00);
                check("bp_hold_tag_b", 32'(out_tag), 32'd1);
                out_ready = 1'b1;
            end
        join
        drain("drain_backpressure");
        lat_chk = 1'b1;

        // Flush with three ops in flight and a fourth offered on the flush edge
        send16(16'h1111, 4'd1, 2'b00, 4'd1, 16'h2222, w);
        send16(16'h2222, 4'd1, 2'b00, 4'd2, 16'h4444, w);
        send16(16'h3333, 4'd1, 2'b00, 4'd3, 16'h6666, w);
        in_data = 16'h4444; in_amt = 4'd1; in_mode = 2'b00; in_tag = 4'd4;
        in_valid = 1'b1; flush = 1'b1;
        @(negedge clk);
        check("flush_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        q16.delete();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("flush_out_valid", 32'(out_valid), 32'd0);
        end
        @(posedge clk); #1;
        send16(16'h00FF, 4'd3, 2'b11, 4'd9, 16'h001F, w);
        in_valid = 1'b0;
        drain("drain_flush");

        // 32-bit instance
        send32(32'h8000_0000, 5'd31, 2'b01, 1'b1, 32'hFFFF_FFFF);
        send32(32'h0000_0001, 5'd1, 2'b10, 1'b0, 32'h8000_0000);
        send32(32'h8000_0000, 5'd1, 2'b00, 1'b1, 32'h0000_0000);
        w_in_valid = 1'b0;
        drain("drain_w32");

        // Asynchronous reset with the pipe full
        lat_chk = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send16(16'hF00D, 4'd0, 2'b00, 4'(i + 5), 16'hF00D, w);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("areset_out_valid", 32'(out_valid), 32'd0);
        check("areset_out_data", 32'(out_data), 32'd0);
        check("areset_out_tag", 32'(out_tag), 32'd0);
        check("areset_out_zero", 32'(out_zero), 32'd1);
        check("areset_in_ready", 32'(in_ready), 32'd1);
        q16.delete();
        @(negedge clk);
        @(negedge clk) rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("post_reset_out_valid", 32'(out_valid), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
